// File: rtl/fact_bus_arbiter.sv
// fact_bus_arbiter
// Two-master, two-slave bus arbiter and address decoder for the factorial
// subsystem. Master 0 (host) is the parking owner; master 1 (factorial core)
// keeps the bus for as long as it requests, with no preemption. Slave-side
// strobes are combinational from the owner; read data returns one cycle later
// through a registered read-select.
module fact_bus_arbiter #(
    parameter int              ADDR_W  = 16,
    parameter int              DATA_W  = 32,
    parameter logic [ADDR_W-1:0] S0_BASE = 16'h0000,
    parameter logic [ADDR_W-1:0] S0_MASK = 16'hF800,
    parameter logic [ADDR_W-1:0] S1_BASE = 16'h7000,
    parameter logic [ADDR_W-1:0] S1_MASK = 16'hFFE0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              M0_req,
    input  logic              M1_req,
    input  logic              M0_wr,
    input  logic              M1_wr,
    input  logic [ADDR_W-1:0] M0_address,
    input  logic [ADDR_W-1:0] M1_address,
    input  logic [DATA_W-1:0] M0_dout,
    input  logic [DATA_W-1:0] M1_dout,
    output logic              M0_grant,
    output logic              M1_grant,
    output logic [ADDR_W-1:0] S_address,
    output logic              S_wr,
    output logic [DATA_W-1:0] S_din,
    output logic              S0_sel,
    output logic              S1_sel,
    input  logic [DATA_W-1:0] S0_dout,
    input  logic [DATA_W-1:0] S1_dout,
    output logic [DATA_W-1:0] M_din,
    output logic              bus_err
);

    localparam logic [0:0] OWN_M0 = 1'b0;
    localparam logic [0:0] OWN_M1 = 1'b1;

    // Address window match: masked address equals the window base.
    function automatic logic addr_hit(
        input logic [ADDR_W-1:0] addr,
        input logic [ADDR_W-1:0] base,
        input logic [ADDR_W-1:0] mask
    );
        return ((addr & mask) == base);
    endfunction

    logic [0:0]        state_r;
    logic [0:0]        state_next_s;
    logic [1:0]        rsel_r;
    logic [1:0]        rsel_next_s;
    logic              bus_err_r;
    logic              bus_err_next_s;

    logic              oreq_s;
    logic              owr_s;
    logic [ADDR_W-1:0] oaddr_s;
    logic [DATA_W-1:0] odata_s;
    logic              hit0_s;
    logic              hit1_s;
    logic              s0_sel_s;
    logic              s1_sel_s;
    logic [DATA_W-1:0] m_din_s;

    // Owner transition: M1 takes a parked bus only when M0 is idle, and
    // keeps it until it stops requesting.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            OWN_M0: begin
                if (!M0_req && M1_req) begin
                    state_next_s = OWN_M1;
                end else begin
                    state_next_s = OWN_M0;
                end
            end
            OWN_M1: begin
                if (!M1_req) begin
                    state_next_s = OWN_M0;
                end else begin
                    state_next_s = OWN_M1;
                end
            end
            default: state_next_s = OWN_M0;
        endcase
    end

    // Owner mux; while reset is held the slave side follows master 0 so an
    // aborted M1 transfer cannot keep driving the slaves.
    always_comb begin
        oreq_s  = M0_req;
        owr_s   = M0_wr;
        oaddr_s = M0_address;
        odata_s = M0_dout;
        if (state_r == OWN_M1 && !reset) begin
            oreq_s  = M1_req;
            owr_s   = M1_wr;
            oaddr_s = M1_address;
            odata_s = M1_dout;
        end else begin
            oreq_s  = M0_req;
            owr_s   = M0_wr;
            oaddr_s = M0_address;
            odata_s = M0_dout;
        end
    end

    // Address decode; S0 takes priority where the two windows overlap.
    always_comb begin
        hit0_s         = addr_hit(oaddr_s, S0_BASE, S0_MASK);
        hit1_s         = addr_hit(oaddr_s, S1_BASE, S1_MASK);
        s0_sel_s       = oreq_s & hit0_s;
        s1_sel_s       = oreq_s & hit1_s & ~hit0_s;
        bus_err_next_s = oreq_s & ~hit0_s & ~hit1_s;
        if (oreq_s && !owr_s) begin
            rsel_next_s = {s1_sel_s, s0_sel_s};
        end else begin
            rsel_next_s = 2'b00;
        end
    end

    // Read-data return steered by last cycle's read-select.
    always_comb begin
        m_din_s = {DATA_W{1'b0}};
        if (rsel_r[0]) begin
            m_din_s = S0_dout;
        end else if (rsel_r[1]) begin
            m_din_s = S1_dout;
        end else begin
            m_din_s = {DATA_W{1'b0}};
        end
    end

    // Owner state, read-select and error pulse registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= OWN_M0;
            rsel_r    <= 2'b00;
            bus_err_r <= 1'b0;
        end else begin
            state_r   <= state_next_s;
            rsel_r    <= rsel_next_s;
            bus_err_r <= bus_err_next_s;
        end
    end

    assign M0_grant  = (state_r == OWN_M0);
    assign M1_grant  = (state_r == OWN_M1);
    assign S_address = oaddr_s;
    assign S_din     = odata_s;
    assign S_wr      = oreq_s & owr_s;
    assign S0_sel    = s0_sel_s;
    assign S1_sel    = s1_sel_s;
    assign M_din     = m_din_s;
    assign bus_err   = bus_err_r;

endmodule

// File: tb/tb_fact_bus_arbiter.sv
// Directed testbench for fact_bus_arbiter.
module tb_fact_bus_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        M0_req, M1_req, M0_wr, M1_wr;
    logic [15:0] M0_address, M1_address;
    logic [31:0] M0_dout, M1_dout;
    logic        M0_grant, M1_grant;
    logic [15:0] S_address;
    logic        S_wr;
    logic [31:0] S_din;
    logic        S0_sel, S1_sel;
    logic [31:0] S0_dout, S1_dout;
    logic [31:0] M_din;
    logic        bus_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fact_bus_arbiter dut (
        .clk(clk), .reset(reset),
        .M0_req(M0_req), .M1_req(M1_req),
        .M0_wr(M0_wr), .M1_wr(M1_wr),
        .M0_address(M0_address), .M1_address(M1_address),
        .M0_dout(M0_dout), .M1_dout(M1_dout),
        .M0_grant(M0_grant), .M1_grant(M1_grant),
        .S_address(S_address), .S_wr(S_wr), .S_din(S_din),
        .S0_sel(S0_sel), .S1_sel(S1_sel),
        .S0_dout(S0_dout), .S1_dout(S1_dout),
        .M_din(M_din), .bus_err(bus_err)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        M0_req = 1'b0; M1_req = 1'b0; M0_wr = 1'b0; M1_wr = 1'b0;
        M0_address = 16'h0000; M1_address = 16'h0000;
        M0_dout = 32'h0; M1_dout = 32'h0;
        S0_dout = 32'hAAAA_5555; S1_dout = 32'h1234_5678;
        step();
        step();
        checks++; if (M0_grant !== 1'b1) begin errors++; $display("FAIL reset_m0_grant got %b exp 1", M0_grant); end
        checks++; if (M1_grant !== 1'b0) begin errors++; $display("FAIL reset_m1_grant got %b exp 0", M1_grant); end
        checks++; if (M_din !== 32'h0) begin errors++; $display("FAIL reset_m_din got %h exp 0", M_din); end
        checks++; if (bus_err !== 1'b0) begin errors++; $display("FAIL reset_bus_err got %b exp 0", bus_err); end
        checks++; if ({S1_sel, S0_sel} !== 2'b00) begin errors++; $display("FAIL reset_sels got %b exp 00", {S1_sel, S0_sel}); end
        reset = 1'b0;
        step();
    endtask

    task automatic test_handoff_write();
        M0_req = 1'b0;
        M1_req = 1'b1; M1_wr = 1'b1; M1_address = 16'h7008; M1_dout = 32'h5;
        #1;
        checks++; if (S1_sel !== 1'b0) begin errors++; $display("FAIL nonowner_ignored got %b exp 0", S1_sel); end
        checks++; if (M0_grant !== 1'b1) begin errors++; $display("FAIL pre_handoff_m0_grant got %b exp 1", M0_grant); end
        step();
        checks++; if ({M1_grant, M0_grant} !== 2'b10) begin errors++; $display("FAIL handoff_grants got %b exp 10", {M1_grant, M0_grant}); end
        checks++; if (S1_sel !== 1'b1) begin errors++; $display("FAIL wr_s1_sel got %b exp 1", S1_sel); end
        checks++; if (S0_sel !== 1'b0) begin errors++; $display("FAIL wr_s0_sel got %b exp 0", S0_sel); end
        checks++; if (S_wr !== 1'b1) begin errors++; $display("FAIL wr_s_wr got %b exp 1", S_wr); end
        checks++; if (S_address !== 16'h7008) begin errors++; $display("FAIL wr_addr got %h exp 7008", S_address); end
        checks++; if (S_din !== 32'h5) begin errors++; $display("FAIL wr_din got %h exp 5", S_din); end
    endtask

    task automatic test_hold_release();
        M0_req = 1'b1; M0_wr = 1'b1; M0_address = 16'h0000;
        for (int i = 0; i < 10; i++) begin
            step();
            checks++; if (M1_grant !== 1'b1) begin errors++; $display("FAIL hold_m1_grant cycle %0d got %b exp 1", i, M1_grant); end
        end
        // last M1 cycle is a read of the register slave
        M1_wr = 1'b0; M1_address = 16'h7004;
        step();
        M1_req = 1'b0;
        S1_dout = 32'h0000_1234;
        #1;
        checks++; if (M_din !== 32'h0000_1234) begin errors++; $display("FAIL release_last_read got %h exp 1234", M_din); end
        step();
        checks++; if ({M1_grant, M0_grant} !== 2'b01) begin errors++; $display("FAIL release_grants got %b exp 01", {M1_grant, M0_grant}); end
        M0_req = 1'b0; M0_wr = 1'b0;
        step();
    endtask

    task automatic test_read_latency();
        M0_req = 1'b1; M0_wr = 1'b0; M0_address = 16'h0010;
        #1;
        checks++; if (S0_sel !== 1'b1) begin errors++; $display("FAIL rd0_s0_sel got %b exp 1", S0_sel); end
        step();
        S0_dout = 32'hDEAD_BEEF; S1_dout = 32'h0000_0099;
        M0_address = 16'h7000;
        #1;
        checks++; if (M_din !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rd0_m_din got %h exp deadbeef", M_din); end
        checks++; if ({S1_sel, S0_sel} !== 2'b10) begin errors++; $display("FAIL rd1_sels got %b exp 10", {S1_sel, S0_sel}); end
        step();
        M0_req = 1'b0;
        S0_dout = 32'h1111_1111; S1_dout = 32'h0000_0078;
        #1;
        checks++; if (M_din !== 32'h0000_0078) begin errors++; $display("FAIL rd1_m_din got %h exp 78", M_din); end
        step();
        checks++; if (M_din !== 32'h0) begin errors++; $display("FAIL idle_m_din got %h exp 0", M_din); end
    endtask

    task automatic test_unmapped();
        M0_req = 1'b1; M0_wr = 1'b0; M0_address = 16'h9000;
        #1;
        checks++; if ({S1_sel, S0_sel} !== 2'b00) begin errors++; $display("FAIL unmapped_sels got %b exp 00", {S1_sel, S0_sel}); end
        step();
        M0_req = 1'b0;
        S0_dout = 32'hFFFF_FFFF; S1_dout = 32'h0000_0042;
        #1;
        checks++; if (bus_err !== 1'b1) begin errors++; $display("FAIL unmapped_err got %b exp 1", bus_err); end
        checks++; if (M_din !== 32'h0) begin errors++; $display("FAIL unmapped_m_din got %h exp 0", M_din); end
        step();
        checks++; if (bus_err !== 1'b0) begin errors++; $display("FAIL unmapped_err_clear got %b exp 0", bus_err); end
    endtask

    task automatic test_reset_mid();
        M0_req = 1'b0;
        M1_req = 1'b1; M1_wr = 1'b0; M1_address = 16'h7004;
        step();
        checks++; if (M1_grant !== 1'b1) begin errors++; $display("FAIL mid_owner got %b exp 1", M1_grant); end
        S1_dout = 32'h0000_0055;
        reset = 1'b1;
        #1;
        checks++; if (S1_sel !== 1'b0) begin errors++; $display("FAIL mid_follow_m0 got %b exp 0", S1_sel); end
        step();
        checks++; if ({M1_grant, M0_grant} !== 2'b01) begin errors++; $display("FAIL mid_grants got %b exp 01", {M1_grant, M0_grant}); end
        checks++; if (M_din !== 32'h0) begin errors++; $display("FAIL mid_m_din got %h exp 0", M_din); end
        reset = 1'b0;
        step();
        checks++; if (M1_grant !== 1'b1) begin errors++; $display("FAIL post_reset_regrant got %b exp 1", M1_grant); end
        M1_req = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_handoff_write();
        test_hold_release();
        test_read_latency();
        test_unmapped();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
